// File: rtl/uart_confreg.sv
// Memory-mapped UART responder: TXDATA stores are queued in a TX FIFO and drained as
// one-cycle character pulses; RXDATA loads fetch one character from the simulator.
module uart_confreg #(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_1000_0000,
    parameter int          TX_DEPTH  = 8,
    parameter int          TX_GAP    = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        conf_en,
    input  logic [7:0]  conf_wen,
    input  logic [63:0] conf_addr,
    input  logic [63:0] conf_wdata,
    output logic [63:0] conf_rdata,
    output logic        uart_out_valid,
    output logic [7:0]  uart_out_ch,
    output logic        uart_in_valid,
    input  logic [7:0]  uart_in_ch
);

    localparam int PTR_W = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int CNT_W = $clog2(TX_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TX_DEPTH);
    localparam logic [7:0]       GAP_C   = 8'(TX_GAP);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [7:0]       tx_mem [TX_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [7:0]       gap_cnt;
    logic [15:0]      drop_cnt;

    logic        hit;
    logic        wr;
    logic [1:0]  sel;
    logic        tx_full;
    logic        tx_empty;
    logic        pop;
    logic        push_req;
    logic        push_ok;
    logic        drop;
    logic [63:0] rd_mux;
    logic [63:0] status;

    // Upper write-data lanes and the byte offset within a register are don't-care.
    logic unused_bits;
    assign unused_bits = ^{conf_wdata[63:8], conf_addr[2:0]};

    // Decode stage: address match, register select and FIFO handshake.
    assign hit      = conf_en && (conf_addr[63:5] == BASE_ADDR[63:5]);
    assign wr       = |conf_wen;
    assign sel      = conf_addr[4:3];
    assign tx_full  = (count == DEPTH_C);
    assign tx_empty = (count == '0);
    assign pop      = !tx_empty && (gap_cnt == 8'd0);
    assign push_req = hit && wr && (sel == 2'd0) && conf_wen[0];
    assign push_ok  = push_req && (!tx_full || pop);
    assign drop     = push_req && !push_ok;

    assign uart_in_valid = rst_n && hit && !wr && (sel == 2'd2);

    assign status = {32'd0, drop_cnt, {(8 - CNT_W){1'b0}}, count, 6'd0, tx_empty, tx_full};

    always_comb begin
        rd_mux = 64'd0;
        unique case (sel)
            2'd1:    rd_mux = status;
            2'd2:    rd_mux = {56'd0, uart_in_ch};
            default: rd_mux = 64'd0;
        endcase
    end

    // Storage stage: FIFO payload carries no reset, pointers decide what is live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            tx_mem[tail] <= conf_wdata[7:0];
        end
    end

    // Output stage: drain, pointer/count bookkeeping and registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            gap_cnt        <= 8'd0;
            drop_cnt       <= 16'd0;
            conf_rdata     <= 64'd0;
            uart_out_valid <= 1'b0;
            uart_out_ch    <= 8'd0;
        end else begin
            if (pop) begin
                head           <= head + 1'b1;
                uart_out_valid <= 1'b1;
                uart_out_ch    <= tx_mem[head];
                gap_cnt        <= GAP_C;
            end else begin
                uart_out_valid <= 1'b0;
                if (gap_cnt != 8'd0) begin
                    gap_cnt <= gap_cnt - 8'd1;
                end
            end

            if (push_ok) begin
                tail <= tail + 1'b1;
            end

            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (drop) begin
                drop_cnt <= sat_inc16(drop_cnt);
            end

            if (hit && !wr) begin
                conf_rdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_uart_confreg.sv
// Directed bench for uart_confreg: two instances (TX_GAP=0 and TX_GAP=255) share stimulus
// and are compared every cycle against a queue-based reference model plus literal checks.
module tb_uart_confreg;

    localparam logic [63:0] BASE = 64'h0000_0000_1000_0000;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [7:0]  wen = 8'd0;
    logic [63:0] addr = 64'd0;
    logic [63:0] wdata = 64'd0;
    logic [7:0]  in_ch = 8'd0;

    logic [63:0] rdata0, rdata1;
    logic        ov0, ov1, iv0, iv1;
    logic [7:0]  och0, och1;

    int n_pass = 0;
    int n_total = 0;
    int cyc_n = 0;
    bit cmp_on = 1'b0;
    bit rec_on = 1'b0;
    bit cnt_on = 1'b0;
    int cnt0 = 0;
    int cnt1 = 0;
    byte unsigned rec_ch[$];
    int           rec_t[$];

    always #5 clk = ~clk;

    uart_confreg #(.BASE_ADDR(BASE), .TX_DEPTH(DEPTH), .TX_GAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .conf_en(en), .conf_wen(wen), .conf_addr(addr),
        .conf_wdata(wdata), .conf_rdata(rdata0), .uart_out_valid(ov0), .uart_out_ch(och0),
        .uart_in_valid(iv0), .uart_in_ch(in_ch)
    );

    uart_confreg #(.BASE_ADDR(BASE), .TX_DEPTH(DEPTH), .TX_GAP(255)) dut1 (
        .clk(clk), .rst_n(rst_n), .conf_en(en), .conf_wen(wen), .conf_addr(addr),
        .conf_wdata(wdata), .conf_rdata(rdata1), .uart_out_valid(ov1), .uart_out_ch(och1),
        .uart_in_valid(iv1), .uart_in_ch(in_ch)
    );

    wire       b_hit  = en && (addr[63:5] == BASE[63:5]);
    wire       b_wr   = |wen;
    wire [1:0] b_reg  = addr[4:3];
    wire       b_push = b_hit && b_wr && (b_reg == 2'd0) && wen[0];

    // Reference model: a character queue, a gap timer and a drop tally per instance.
    for (genvar g = 0; g < 2; g++) begin : mdl
        localparam int GAP = (g == 0) ? 0 : 255;
        byte unsigned q[$];
        int           gap = 0;
        int           drop = 0;
        logic [63:0]  rdata = 64'd0;
        logic         valid = 1'b0;
        logic [7:0]   ch = 8'd0;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q.delete();
                gap = 0;
                drop = 0;
                rdata = 64'd0;
                valid = 1'b0;
                ch = 8'd0;
            end else begin
                if (b_hit && !b_wr) begin
                    case (b_reg)
                        2'd1: rdata = {32'd0, drop[15:0], 8'(q.size()), 6'd0,
                                       (q.size() == 0), (q.size() == DEPTH)};
                        2'd2: rdata = {56'd0, in_ch};
                        default: rdata = 64'd0;
                    endcase
                end
                if (q.size() > 0 && gap == 0) begin
                    ch = q.pop_front();
                    valid = 1'b1;
                    gap = GAP;
                end else begin
                    valid = 1'b0;
                    if (gap > 0) gap--;
                end
                if (b_push) begin
                    if (q.size() < DEPTH) q.push_back(wdata[7:0]);
                    else if (drop < 65535) drop++;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Per-cycle comparison against the model, sampled 1 time unit after the edge.
    always @(posedge clk) begin
        cyc_n++;
        #1;
        if (cmp_on) begin
            check("rdata0", rdata0, mdl[0].rdata);
            check("rdata1", rdata1, mdl[1].rdata);
            check("valid0", {63'd0, ov0}, {63'd0, mdl[0].valid});
            check("valid1", {63'd0, ov1}, {63'd0, mdl[1].valid});
            if (mdl[0].valid) check("ch0", {56'd0, och0}, {56'd0, mdl[0].ch});
            if (mdl[1].valid) check("ch1", {56'd0, och1}, {56'd0, mdl[1].ch});
            check("in_valid", {63'd0, iv0},
                  {63'd0, rst_n && b_hit && !b_wr && (b_reg == 2'd2)});
            check("in_valid1", {63'd0, iv1}, {63'd0, iv0});
        end
        if (rec_on && ov1) begin
            rec_ch.push_back(och1);
            rec_t.push_back(cyc_n);
        end
        if (cnt_on) begin
            if (ov0) cnt0++;
            if (ov1) cnt1++;
        end
    end

    task automatic cyc(input logic e, input logic [7:0] w, input logic [63:0] a, input logic [63:0] d);
        en = e; wen = w; addr = a; wdata = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'd0, 64'd0, 64'd0);
    endtask

    initial begin
        @(negedge clk);
        cmp_on = 1'b1;

        // Reset held while traffic is driven: everything stays quiet.
        cyc(1'b1, 8'h01, BASE, 64'h55);
        en = 1'b1; wen = 8'd0; addr = BASE + 64'h10; in_ch = 8'h41;
        #1 check("rst_in_valid", {63'd0, iv0}, 64'd0);
        @(negedge clk);
        check("rst_rdata0", rdata0, 64'd0);
        check("rst_rdata1", rdata1, 64'd0);
        check("rst_valid", {62'd0, ov0, ov1}, 64'd0);
        check("rst_ch", {48'd0, och0, och1}, 64'd0);
        idle(1);
        rst_n = 1'b1;
        idle(1);
        cyc(1'b1, 8'd0, BASE + 64'h08, 64'd0);
        check("status_after_rst0", rdata0, 64'h2);
        check("status_after_rst1", rdata1, 64'h2);

        // "Hi" on consecutive cycles.
        cyc(1'b1, 8'h01, BASE, 64'h48);
        check("hi_early", {63'd0, ov0}, 64'd0);
        cyc(1'b1, 8'h01, BASE, 64'h69);
        check("hi_v1", {63'd0, ov0}, 64'd1);
        check("hi_c1", {56'd0, och0}, 64'h48);
        check("hi_g_c1", {55'd0, ov1, och1}, 64'h148);
        idle(1);
        check("hi_v2", {63'd0, ov0}, 64'd1);
        check("hi_c2", {56'd0, och0}, 64'h69);
        check("hi_g_v2", {63'd0, ov1}, 64'd0);
        idle(1);
        check("hi_v3", {63'd0, ov0}, 64'd0);

        // RXDATA fetch and hold.
        en = 1'b1; wen = 8'd0; addr = BASE + 64'h10; in_ch = 8'h41;
        #1 check("rx_req", {63'd0, iv0}, 64'd1);
        @(negedge clk);
        en = 1'b0; in_ch = 8'h7E;
        #1 check("rx_req_off", {63'd0, iv0}, 64'd0);
        check("rx_data", rdata0, 64'h41);
        idle(3);
        check("rx_hold0", rdata0, 64'h41);
        check("rx_hold1", rdata1, 64'h41);
        in_ch = 8'hFF;
        cyc(1'b1, 8'd0, BASE + 64'h10, 64'd0);
        check("rx_none", rdata0, 64'hFF);

        // Misses, foreign lanes and the reserved slot.
        cyc(1'b1, 8'd0, BASE + 64'h50, 64'd0);
        check("miss_read_hold", rdata0, 64'hFF);
        cyc(1'b1, 8'h02, BASE, 64'h5A);
        cyc(1'b1, 8'hFF, BASE + 64'h40, 64'h5B);
        check("write_hold", rdata0, 64'hFF);
        cyc(1'b1, 8'd0, BASE + 64'h08, 64'd0);
        check("no_push_status", rdata0, 64'h2);
        cyc(1'b1, 8'd0, BASE + 64'h18, 64'd0);
        check("reserved_read", rdata0, 64'd0);
        idle(600);

        // Overflow with a 255-cycle gap: 9 accepted, 3 dropped.
        rec_on = 1'b1;
        for (int k = 0; k < 12; k++) cyc(1'b1, 8'h01, BASE, 64'(8'h41 + k));
        cyc(1'b1, 8'd0, BASE + 64'h08, 64'd0);
        check("ovf_status", rdata1, 64'h0000_0000_0003_0801);
        idle(2400);
        rec_on = 1'b0;
        check("ovf_count", 64'(rec_ch.size()), 64'd9);
        for (int k = 0; k < rec_ch.size(); k++) begin
            check("ovf_char", {56'd0, rec_ch[k]}, 64'(8'h41 + k));
            if (k > 0) check("ovf_spacing", 64'(rec_t[k] - rec_t[k-1]), 64'd256);
        end

        // Reset in the middle of a drain.
        for (int k = 0; k < 6; k++) cyc(1'b1, 8'h01, BASE, 64'(8'h61 + k));
        check("pre_rst_v", {55'd0, ov0, och0}, 64'h165);
        rst_n = 1'b0;
        en = 1'b0; wen = 8'd0;
        #1 check("rst_drop_v", {62'd0, ov0, ov1}, 64'd0);
        check("rst_drop_ch", {48'd0, och0, och1}, 64'd0);
        idle(3);
        rst_n = 1'b1;
        cnt_on = 1'b1;
        idle(600);
        cnt_on = 1'b0;
        check("stale0", 64'(cnt0), 64'd0);
        check("stale1", 64'(cnt1), 64'd0);
        cyc(1'b1, 8'd0, BASE + 64'h08, 64'd0);
        check("post_rst_status0", rdata0, 64'h2);
        check("post_rst_status1", rdata1, 64'h2);
        idle(2);

        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
